// File: rtl/ooops_pipe_reg_pkg.sv
// Shared constants and helpers for the ooops elastic pipeline register.
package ooops_pipe_reg_pkg;

  // Largest supported number of register stages.
  localparam int unsigned PIPE_MAX_DEPTH = 8;

  // Width of the occupancy counter: must hold DEPTH+1 when the skid is enabled.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/ooops_pipe_stage.sv
// One elastic stage: valid bit plus loadable DW-bit data flop, async reset to RST_VAL.
module ooops_pipe_stage
  import ooops_pipe_reg_pkg::*;
#(
  parameter int unsigned   DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          src_vld,
  input  logic [DW-1:0] src_data,
  output logic          vld,
  output logic [DW-1:0] data
);

  // Valid bit: cleared by flush, otherwise follows the source on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= src_vld;
    end
  end

  // Data only captures real beats; bubbles leave the old payload in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= RST_VAL;
    end else if (load && src_vld && !flush) begin
      data <= src_data;
    end
  end

endmodule

// File: rtl/ooops_pipe_reg.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshakes, bubble
// collapsing, flush and occupancy count. Define OOOPS_PIPE_SKID_EN to add a
// one-entry skid in front of stage 0 that registers in_rdy.
module ooops_pipe_reg
  import ooops_pipe_reg_pkg::*;
#(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   DEPTH   = 2,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [DW-1:0]                in_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(DEPTH+2)-1:0]   count
);

  localparam int unsigned CW = cnt_width(DEPTH);

  // Reject unsupported configurations at elaboration.
  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("ooops_pipe_reg: DEPTH out of range");
  end
  if (DW < 1) begin : g_bad_dw
    $error("ooops_pipe_reg: DW must be at least 1");
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [DW-1:0]    d     [DEPTH];
  logic [DW-1:0]    src_d [DEPTH];
  logic             run;
  logic             in_fire;
  logic             out_fire;
  logic             s0_vld;
  logic [DW-1:0]    s0_data;

  // Advance chain: a stage may load if it or any stage downstream has a hole,
  // or the output is being drained.
  always_comb begin
    run = out_rdy;
    adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      run    = run | ~v[i];
      adv[i] = run;
    end
  end

  assign in_fire  = in_vld & in_rdy;
  assign out_fire = out_vld & out_rdy;

`ifdef OOOPS_PIPE_SKID_EN
  logic          skid_v;
  logic          skid_src;
  logic          skid_load;
  logic [DW-1:0] skid_d;

  // Skid catches a beat stage 0 cannot take, and drains ahead of new input.
  assign skid_src  = in_fire & ~adv[0];
  assign skid_load = skid_src | (skid_v & adv[0]);

  ooops_pipe_stage #(
    .DW      (DW),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (skid_load),
    .src_vld  (skid_src),
    .src_data (in_data),
    .vld      (skid_v),
    .data     (skid_d)
  );

  assign in_rdy  = ~skid_v & ~flush & rst;
  assign s0_vld  = skid_v | in_fire;
  assign s0_data = skid_v ? skid_d : in_data;
`else
  assign in_rdy  = adv[0] & ~flush & rst;
  assign s0_vld  = in_fire;
  assign s0_data = in_data;
`endif

  // Stage chain: stage 0 fed from the input side, stage i from stage i-1.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign src_v[g] = s0_vld;
      assign src_d[g] = s0_data;
    end else begin : g_body
      assign src_v[g] = v[g-1];
      assign src_d[g] = d[g-1];
    end

    ooops_pipe_stage #(
      .DW      (DW),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (adv[g]),
      .src_vld  (src_v[g]),
      .src_data (src_d[g]),
      .vld      (v[g]),
      .data     (d[g])
    );
  end

  assign out_vld  = v[DEPTH-1];
  assign out_data = d[DEPTH-1];

  // Occupancy: +1 per input beat, -1 per output beat, zeroed by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + CW'(1);
    end else if (!in_fire && out_fire) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_ooops_pipe_reg.sv
// Self-checking bench for ooops_pipe_reg: directed scenarios plus random
// traffic against a slot-position queue model.
module tb_ooops_pipe_reg;

  localparam int DW    = 32;
  localparam int DEPTH = 3;
`ifdef OOOPS_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = SKID ? DEPTH + 1 : DEPTH;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic                       in_vld;
  logic                       in_rdy;
  logic [DW-1:0]              in_data;
  logic                       out_vld;
  logic                       out_rdy;
  logic [DW-1:0]              out_data;
  logic [$clog2(DEPTH+2)-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: one entry per held beat, oldest first; position = stage index,
  // -1 for the skid slot.
  int            q_pos[$];
  logic [DW-1:0] q_dat[$];

  ooops_pipe_reg #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, check outputs against the model, advance the model.
  // Entered and left just after a rising edge.
  task automatic cycle(input logic v, input logic [DW-1:0] dat, input logic ordy, input logic fl);
    int   npos[$];
    logic exp_ovld;
    logic exp_irdy;
    logic pop;
    logic s0_free;
    logic skid_busy;
    in_vld  = v;
    in_data = dat;
    out_rdy = ordy;
    flush   = fl;
    #1;
    exp_ovld  = (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1);
    pop       = exp_ovld & ordy;
    skid_busy = (q_pos.size() > 0) && (q_pos[q_pos.size()-1] < 0);
    // Each beat moves forward one slot if the slot ahead is empty after the move.
    for (int k = 0; k < q_pos.size(); k++) begin
      if (!(k == 0 && pop)) begin
        if (npos.size() == 0)
          npos.push_back((q_pos[k] < DEPTH - 1) ? q_pos[k] + 1 : q_pos[k]);
        else
          npos.push_back((q_pos[k] + 1 != npos[npos.size()-1]) ? q_pos[k] + 1 : q_pos[k]);
      end
    end
    s0_free  = (npos.size() == 0) || (npos[npos.size()-1] > 0);
    exp_irdy = !fl && (SKID ? !skid_busy : s0_free);
    chk("out_vld", 64'(out_vld), 64'(exp_ovld));
    chk("in_rdy", 64'(in_rdy), 64'(exp_irdy));
    chk("count", 64'(count), 64'(q_pos.size()));
    if (exp_ovld) chk("out_data", 64'(out_data), 64'(q_dat[0]));
    if (pop) void'(q_dat.pop_front());
    if (fl) begin
      npos.delete();
      q_dat.delete();
    end else if (v && exp_irdy) begin
      npos.push_back(s0_free ? 0 : -1);
      q_dat.push_back(dat);
    end
    q_pos = npos;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  int peak;

  initial begin
    // Reset held with traffic on the input.
    rst     = 1'b0;
    flush   = 1'b0;
    in_vld  = 1'b1;
    in_data = 32'hDEADBEEF;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    rst    = 1'b1;
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);

    // Streaming: three back-to-back beats with the output open.
    peak = 0;
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, DW'(i), 1'b1, 1'b0);
      if (int'(count) > peak) peak = int'(count);
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      if (int'(count) > peak) peak = int'(count);
    end
    chk("stream_peak", 64'(peak), 64'((DEPTH < 3) ? DEPTH : 3));

    // Back-pressure: push four beats into a stalled pipe.
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    chk("bp_count", 64'(count), 64'(CAP));
    chk("bp_in_rdy", 64'(in_rdy), 64'd0);
    drain(DEPTH + 3);
    chk("bp_drained", 64'(count), 64'd0);

    // Bubble collapse: A, hole, B, then settle with output stalled.
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("bub_count", 64'(count), 64'd2);
    chk("bub_out_data", 64'(out_data), 64'hA);
    chk("bub_in_rdy", 64'(in_rdy), 64'd1);
    drain(DEPTH + 2);

    // Flush a full pipe with a beat offered in the flush cycle.
    for (int i = 0; i < CAP; i++) cycle(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
    cycle(1'b1, 32'h2FF, 1'b0, 1'b1);
    chk("fl_out_vld", 64'(out_vld), 64'd0);
    chk("fl_count", 64'(count), 64'd0);
    cycle(1'b1, 32'h55, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("fl_lat_vld", 64'(out_vld), 64'd1);
    chk("fl_lat_data", 64'(out_data), 64'h55);
    drain(DEPTH + 1);

    // Random traffic.
    for (int n = 0; n < 10000; n++)
      cycle($urandom_range(3, 0) != 0, $urandom, $urandom_range(7, 0) < 5,
            $urandom_range(63, 0) == 0);

    // Reset mid-stream with the pipe loaded.
    for (int i = 0; i < CAP; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    rst    = 1'b0;
    in_vld = 1'b1;
    #1;
    chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    q_pos.delete();
    q_dat.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int n = 0; n < 200; n++)
      cycle($urandom_range(1, 0) != 0, $urandom, $urandom_range(1, 0) != 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
